// File: rtl/mlow_audio_if_if.sv
// rtl/mlow_audio_if_if.sv - sample stream, playback and frame handshake bundle for mlow_audio_if
// Signal names are as seen from the frame-assembly block; slave is the block, master its environment.
interface mlow_audio_if_if #(
  parameter int FRAME_SIZE = 480
);
  logic [15:0]              audio_data_i;
  logic                     audio_valid_i;
  logic                     audio_ready_o;
  logic [15:0]              audio_data_o;
  logic                     audio_valid_o;
  logic                     audio_ready_i;
  logic [15:0]              frame_data_o;
  logic [FRAME_SIZE-1:0]    frame_data_valid_o;
  logic                     frame_valid_o;
  logic                     frame_ready_i;
  logic [FRAME_SIZE*16-1:0] frame_data_bus_o;
  logic                     frame_bus_valid_o;
  logic                     frame_bus_ready_i;

  modport slave (
    input  audio_data_i, audio_valid_i, audio_ready_i, frame_ready_i, frame_bus_ready_i,
    output audio_ready_o, audio_data_o, audio_valid_o, frame_data_o, frame_data_valid_o,
           frame_valid_o, frame_data_bus_o, frame_bus_valid_o
  );

  modport master (
    output audio_data_i, audio_valid_i, audio_ready_i, frame_ready_i, frame_bus_ready_i,
    input  audio_ready_o, audio_data_o, audio_valid_o, frame_data_o, frame_data_valid_o,
           frame_valid_o, frame_data_bus_o, frame_bus_valid_o
  );
endinterface

// File: rtl/mlow_audio_if.sv
// rtl/mlow_audio_if.sv - MLow frame assembly: collects FRAME_SIZE PCM samples and presents the frame
// Optional playback of each completed frame is compiled in with MLOW_AIF_LOOPBACK_EN.
module mlow_audio_if #(
  parameter int SAMPLE_RATE = 48000,
  parameter int FRAME_SIZE  = 480
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  mlow_audio_if_if.slave bus
);
  localparam int               IDX_W    = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SIZE - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic [15:0]              frame_data_q, frame_data_d;
  logic [FRAME_SIZE-1:0]    dvalid_q, dvalid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     bus_done_q, bus_done_d;
  logic                     ready_q, ready_d;
  logic [15:0]              buf_q [FRAME_SIZE];
  logic [FRAME_SIZE*16-1:0] bus_flat;

  logic accept;
  logic frame_valid;
  logic bus_valid;
  logic frame_hs;
  logic bus_hs;
  logic play_done_d;
  logic release_frame;
  logic unused_rate;

  assign unused_rate = ^SAMPLE_RATE;

  // ready_q is registered so it reads 0 throughout reset and drops on the same edge that takes the last sample
  assign accept      = (state_q == ST_FILL) && ready_q && bus.audio_valid_i;
  assign frame_valid = (state_q == ST_FULL) && !frame_done_q;
  assign bus_valid   = (state_q == ST_FULL) && !bus_done_q;
  assign frame_hs    = frame_valid && bus.frame_ready_i;
  assign bus_hs      = bus_valid && bus.frame_bus_ready_i;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    frame_data_d  = frame_data_q;
    dvalid_d      = dvalid_q;
    frame_done_d  = frame_done_q;
    bus_done_d    = bus_done_q;
    release_frame = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          frame_data_d       = bus.audio_data_i;
          dvalid_d[wr_idx_q] = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = ST_FULL;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        frame_done_d = frame_done_q | frame_hs;
        bus_done_d   = bus_done_q | bus_hs;
        // Release on the edge that completes the last outstanding handshake
        if (frame_done_d && bus_done_d && play_done_d) begin
          release_frame = 1'b1;
          state_d       = ST_FILL;
          wr_idx_d      = '0;
          dvalid_d      = '0;
          frame_done_d  = 1'b0;
          bus_done_d    = 1'b0;
        end
      end
      default: state_d = ST_FILL;
    endcase
    ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_FILL;
      wr_idx_q     <= '0;
      frame_data_q <= '0;
      dvalid_q     <= '0;
      frame_done_q <= 1'b0;
      bus_done_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      frame_data_q <= frame_data_d;
      dvalid_q     <= dvalid_d;
      frame_done_q <= frame_done_d;
      bus_done_q   <= bus_done_d;
      ready_q      <= ready_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < FRAME_SIZE; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept) begin
      buf_q[wr_idx_q] <= bus.audio_data_i;
    end
  end

  always_comb begin
    bus_flat = '0;
    for (int i = 0; i < FRAME_SIZE; i++) begin
      bus_flat[16*i +: 16] = buf_q[i];
    end
  end

`ifdef MLOW_AIF_LOOPBACK_EN
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             play_done_q;
  logic             play_valid;
  logic             play_hs;

  assign play_valid = (state_q == ST_FULL) && !play_done_q;
  assign play_hs    = play_valid && bus.audio_ready_i;

  always_comb begin
    rd_idx_d    = rd_idx_q;
    play_done_d = play_done_q;
    if (play_hs) begin
      if (rd_idx_q == LAST_IDX) begin
        play_done_d = 1'b1;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_idx_q    <= '0;
      play_done_q <= 1'b0;
    end else if (release_frame) begin
      rd_idx_q    <= '0;
      play_done_q <= 1'b0;
    end else begin
      rd_idx_q    <= rd_idx_d;
      play_done_q <= play_done_d;
    end
  end

  assign bus.audio_valid_o = play_valid;
  assign bus.audio_data_o  = play_valid ? buf_q[rd_idx_q] : 16'h0000;
`else
  logic unused_loopback;

  assign play_done_d       = 1'b1;
  assign unused_loopback   = bus.audio_ready_i;
  assign bus.audio_valid_o = 1'b0;
  assign bus.audio_data_o  = 16'h0000;
`endif

  assign bus.audio_ready_o      = ready_q;
  assign bus.frame_data_o       = frame_data_q;
  assign bus.frame_data_valid_o = dvalid_q;
  assign bus.frame_valid_o      = frame_valid;
  assign bus.frame_bus_valid_o  = bus_valid;
  assign bus.frame_data_bus_o   = bus_flat;
endmodule

// File: tb/tb_mlow_audio_if.sv
// tb/tb_mlow_audio_if.sv - directed-vector bench for mlow_audio_if (both MLOW_AIF_LOOPBACK_EN builds)
module tb_mlow_audio_if;
  localparam int FS = 480;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  mlow_audio_if_if #(.FRAME_SIZE(FS)) aif ();

  mlow_audio_if #(
    .SAMPLE_RATE(48000),
    .FRAME_SIZE (FS)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bus      (aif)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // All consumers ready until the block returns to FILL, bounded
  task automatic drain();
    aif.frame_ready_i     = 1'b1;
    aif.frame_bus_ready_i = 1'b1;
    aif.audio_ready_i     = 1'b1;
    for (int c = 0; c < 4 * FS && !aif.audio_ready_o; c++) step();
    aif.frame_ready_i     = 1'b0;
    aif.frame_bus_ready_i = 1'b0;
    aif.audio_ready_i     = 1'b0;
    check("drain_release", {31'b0, aif.audio_ready_o}, 32'd1);
  endtask

  initial begin
    int          k;
    int          n;
    logic        v;
    logic [15:0] exp_fd;

    aif.audio_data_i      = '0;
    aif.audio_valid_i     = 1'b0;
    aif.audio_ready_i     = 1'b0;
    aif.frame_ready_i     = 1'b0;
    aif.frame_bus_ready_i = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", {31'b0, aif.audio_ready_o}, 32'd0);
    check("rst_fvalid", {31'b0, aif.frame_valid_o}, 32'd0);
    check("rst_bvalid", {31'b0, aif.frame_bus_valid_o}, 32'd0);
    check("rst_avalid", {31'b0, aif.audio_valid_o}, 32'd0);
    check("rst_adata", {16'b0, aif.audio_data_o}, 32'd0);
    check("rst_fdata", {16'b0, aif.frame_data_o}, 32'd0);
    check("rst_dvalid", {31'b0, |aif.frame_data_valid_o}, 32'd0);
    check("rst_bus", {31'b0, |aif.frame_data_bus_o}, 32'd0);
    reset_n_i = 1'b1;
    step();
    check("post_rst_ready", {31'b0, aif.audio_ready_o}, 32'd1);
    check("post_rst_fvalid", {31'b0, aif.frame_valid_o}, 32'd0);

    // Frame 1: samples 0..FS-1 back to back, consumers not ready
    aif.audio_valid_i = 1'b1;
    for (int i = 0; i < FS; i++) begin
      aif.audio_data_i = 16'(i);
      if (i == FS - 1) check("pre_last_fvalid", {31'b0, aif.frame_valid_o}, 32'd0);
      step();
      check("f1_fdata", {16'b0, aif.frame_data_o}, 32'(i));
    end
    check("f1_fvalid", {31'b0, aif.frame_valid_o}, 32'd1);
    check("f1_bvalid", {31'b0, aif.frame_bus_valid_o}, 32'd1);
    check("f1_ready", {31'b0, aif.audio_ready_o}, 32'd0);
    check("f1_dvalid_all", {31'b0, &aif.frame_data_valid_o}, 32'd1);
    for (int i = 0; i < FS; i++) check("f1_bus", {16'b0, aif.frame_data_bus_o[16*i +: 16]}, 32'(i));

    aif.audio_data_i = 16'hFFFF;
    for (int c = 0; c < 100; c++) begin
      step();
      check("hold_ready", {31'b0, aif.audio_ready_o}, 32'd0);
    end
    check("hold_fdata", {16'b0, aif.frame_data_o}, 32'(FS - 1));
    check("hold_fvalid", {31'b0, aif.frame_valid_o}, 32'd1);
    check("hold_bus_last", {16'b0, aif.frame_data_bus_o[16*(FS-1) +: 16]}, 32'(FS - 1));
`ifndef MLOW_AIF_LOOPBACK_EN
    check("nolb_avalid", {31'b0, aif.audio_valid_o}, 32'd0);
    check("nolb_adata", {16'b0, aif.audio_data_o}, 32'd0);
`endif
    aif.audio_valid_i = 1'b0;

    // Independent handshakes: frame at cycle 3, bus at cycle 7
    step();
    step();
    aif.frame_ready_i = 1'b1;
    step();
    aif.frame_ready_i = 1'b0;
    check("hs3_fvalid", {31'b0, aif.frame_valid_o}, 32'd0);
    check("hs3_bvalid", {31'b0, aif.frame_bus_valid_o}, 32'd1);
    check("hs3_ready", {31'b0, aif.audio_ready_o}, 32'd0);
    step();
    step();
    step();
    check("hs6_ready", {31'b0, aif.audio_ready_o}, 32'd0);
    check("hs6_dvalid_all", {31'b0, &aif.frame_data_valid_o}, 32'd1);
    aif.frame_bus_ready_i = 1'b1;
    step();
    aif.frame_bus_ready_i = 1'b0;
    check("hs7_bvalid", {31'b0, aif.frame_bus_valid_o}, 32'd0);
    check("hs7_fvalid", {31'b0, aif.frame_valid_o}, 32'd0);
`ifdef MLOW_AIF_LOOPBACK_EN
    check("hs7_ready_wait_play", {31'b0, aif.audio_ready_o}, 32'd0);
    k = 0;
    for (int c = 0; c < 4 * FS && k < FS; c++) begin
      aif.audio_ready_i = ((c % 2) == 1);
      if (aif.audio_valid_o && aif.audio_ready_i) begin
        check("lb_adata", {16'b0, aif.audio_data_o}, 32'(k));
        if (k == FS - 1) check("lb_hold_ready", {31'b0, aif.audio_ready_o}, 32'd0);
        k++;
      end
      step();
    end
    aif.audio_ready_i = 1'b0;
    check("lb_count", 32'(k), 32'(FS));
    check("lb_avalid_off", {31'b0, aif.audio_valid_o}, 32'd0);
`endif
    check("rel_ready", {31'b0, aif.audio_ready_o}, 32'd1);
    check("rel_dvalid", {31'b0, |aif.frame_data_valid_o}, 32'd0);

    // Reset in the middle of a frame
    aif.audio_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      aif.audio_data_i = 16'h0100 + 16'(i);
      step();
    end
    aif.audio_valid_i = 1'b0;
    check("mid_fdata", {16'b0, aif.frame_data_o}, 32'h0163);
    #2 reset_n_i = 1'b0;
    #1;
    check("mrst_ready", {31'b0, aif.audio_ready_o}, 32'd0);
    check("mrst_fdata", {16'b0, aif.frame_data_o}, 32'd0);
    check("mrst_dvalid", {31'b0, |aif.frame_data_valid_o}, 32'd0);
    check("mrst_bus", {31'b0, |aif.frame_data_bus_o}, 32'd0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    step();
    check("mrst_ready_back", {31'b0, aif.audio_ready_o}, 32'd1);
    aif.audio_valid_i = 1'b1;
    aif.audio_data_i  = 16'hA5A5;
    step();
    check("a5_fdata", {16'b0, aif.frame_data_o}, 32'h0000A5A5);
    check("a5_dvalid0", {31'b0, aif.frame_data_valid_o[0]}, 32'd1);
    check("a5_dvalid1", {31'b0, aif.frame_data_valid_o[1]}, 32'd0);
    for (int i = 1; i < FS; i++) step();
    aif.audio_valid_i = 1'b0;
    check("a5_fvalid", {31'b0, aif.frame_valid_o}, 32'd1);
    for (int i = 0; i < FS; i++) check("a5_bus", {16'b0, aif.frame_data_bus_o[16*i +: 16]}, 32'h0000A5A5);
    drain();
    check("a5_fvalid_off", {31'b0, aif.frame_valid_o}, 32'd0);

    // Irregular valid with gaps
    n      = 0;
    exp_fd = 16'hA5A5;
    for (int c = 0; c < 8 * FS && n < FS; c++) begin
      v = ((c % 5) != 2) && ((c % 7) != 4);
      aif.audio_valid_i = v;
      aif.audio_data_i  = 16'h3000 + 16'(n);
      step();
      if (v) begin
        exp_fd = 16'h3000 + 16'(n);
        n++;
      end
      check("irr_fdata", {16'b0, aif.frame_data_o}, {16'b0, exp_fd});
    end
    check("irr_count", 32'(n), 32'(FS));
    check("irr_fvalid", {31'b0, aif.frame_valid_o}, 32'd1);
    check("irr_ready", {31'b0, aif.audio_ready_o}, 32'd0);
    aif.audio_valid_i = 1'b1;
    aif.audio_data_i  = 16'hBEEF;
    step();
    aif.audio_valid_i = 1'b0;
    check("irr_no_extra", {16'b0, aif.frame_data_o}, 32'h3000 + 32'(FS - 1));
    for (int i = 0; i < FS; i++) check("irr_bus", {16'b0, aif.frame_data_bus_o[16*i +: 16]}, 32'h3000 + 32'(i));
    drain();
    check("end_fvalid", {31'b0, aif.frame_valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
